// File: rtl/sha256_host_pkg.sv
// +--------------------------------------------------------------------+
// | sha256_host_pkg : shared types and sizes for the SHA-256 host driver |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package sha256_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DIGEST_BYTES  = 32;
  localparam int MAX_BLOCK_MSG = 55;
  localparam int PTR_W         = 6;
  localparam int TIMER_W       = 10;

endpackage

`default_nettype wire

// File: rtl/sha256_msg_buffer.sv
// +--------------------------------------------------------------------+
// | sha256_msg_buffer : DEPTH x 8 message store, one write, one read     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module sha256_msg_buffer
  import sha256_host_pkg::*;
#(
  parameter int DEPTH = MAX_BLOCK_MSG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (wr_en && (wr_addr < PTR_W'(DEPTH))) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Reading one past the last entry happens at the tail of a burst; return zero.
  assign rd_data = (rd_addr < PTR_W'(DEPTH)) ? r_mem[rd_addr] : 8'h00;

endmodule

`default_nettype wire

// File: rtl/sha256_host_driver.sv
// +--------------------------------------------------------------------+
// | sha256_host_driver : buffers a message, bursts it to the hasher and  |
// | collects the 32-byte digest. Rev 1.0                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module sha256_host_driver
  import sha256_host_pkg::*;
#(
  parameter int MAX_LEN = MAX_BLOCK_MSG,
  parameter int TIMEOUT = 511
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [5:0]   msg_len,
  input  logic         src_valid,
  input  logic [7:0]   src_data,
  output logic         src_ready,
  output logic [7:0]   hs_byte,
  output logic         hs_strobe,
  input  logic [7:0]   hs_digest,
  input  logic         hs_digest_valid,
  output logic [255:0] digest,
  output logic         done,
  output logic         busy,
  output logic         cmd_err,
  output logic         timeout_err,
  output logic         short_err
);

  state_t               r_state;
  state_t               w_next;
  logic [PTR_W-1:0]     r_len;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_byte_cnt;
  logic [TIMER_W-1:0]   r_timer;
  // Holds the first 31 digest bytes; the 32nd is merged straight into digest.
  logic [247:0]         r_shadow;

  logic                 w_accept;
  logic                 w_cmd_err;
  logic                 w_timeout_err;
  logic                 w_short_err;
  logic [PTR_W-1:0]     w_rd_addr;
  logic [7:0]           w_buf_rd;
  logic [7:0]           w_rd_byte;
  logic                 w_src_ready_nx;
  logic                 w_strobe_nx;
  logic                 w_busy_nx;
  logic                 w_done_nx;

  assign w_accept  = (r_state == ST_FILL) && src_valid && src_ready;
  assign w_rd_addr = (r_state == ST_FILL) ? '0 : r_rd_ptr + 1'b1;
  // A one-byte message is written and loaded onto hs_byte on the same edge.
  assign w_rd_byte = (w_accept && (r_wr_ptr == w_rd_addr)) ? src_data : w_buf_rd;

  sha256_msg_buffer #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_accept),
    .wr_addr (r_wr_ptr),
    .wr_data (src_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_cmd_err     = 1'b0;
    w_timeout_err = 1'b0;
    w_short_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((msg_len != '0) && (msg_len <= PTR_W'(MAX_LEN))) w_next = ST_FILL;
          else                                                 w_cmd_err = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_accept && (r_wr_ptr == r_len - 1'b1)) w_next = ST_SEND;
      end
      ST_SEND: begin
        if (r_rd_ptr == r_len - 1'b1) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (hs_digest_valid) begin
          w_next = ST_CAPTURE;
        end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
          w_next        = ST_IDLE;
          w_timeout_err = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!hs_digest_valid) begin
          w_next      = ST_IDLE;
          w_short_err = 1'b1;
        end else if (r_byte_cnt == PTR_W'(DIGEST_BYTES - 1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_src_ready_nx = (w_next == ST_FILL);
    w_strobe_nx    = (w_next == ST_SEND);
    w_busy_nx      = (w_next != ST_IDLE);
    w_done_nx      = (w_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ready   <= 1'b0;
      hs_strobe   <= 1'b0;
      hs_byte     <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
      short_err   <= 1'b0;
      digest      <= '0;
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_byte_cnt  <= '0;
      r_timer     <= '0;
      r_shadow    <= '0;
    end else begin
      src_ready   <= w_src_ready_nx;
      hs_strobe   <= w_strobe_nx;
      busy        <= w_busy_nx;
      done        <= w_done_nx;
      cmd_err     <= w_cmd_err;
      timeout_err <= w_timeout_err;
      short_err   <= w_short_err;
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_FILL) begin
            r_len    <= msg_len;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end
        end
        ST_FILL: begin
          if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_next == ST_SEND) begin
            hs_byte  <= w_rd_byte;
            r_rd_ptr <= '0;
          end
        end
        ST_SEND: begin
          if (w_next == ST_SEND) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            hs_byte  <= w_rd_byte;
          end else begin
            hs_byte <= 8'h00;
            r_timer <= '0;
          end
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (hs_digest_valid) begin
            r_shadow   <= {r_shadow[239:0], hs_digest};
            r_byte_cnt <= PTR_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (hs_digest_valid) begin
            r_shadow   <= {r_shadow[239:0], hs_digest};
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
          if (w_next == ST_DONE) digest <= {r_shadow, hs_digest};
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sha256_host_driver.md
# sha256_host_driver

Host-side counterpart of the byte-serial SHA-256 hasher. It collects a single-block message (1–55 bytes) from an upstream valid/ready byte source into a local buffer, then replays it to the hasher as one unbroken strobe burst. It then waits for the hasher's digest stream, captures the 32 digest bytes and presents them as a 256-bit word with a one-cycle `done`. It sits between the system byte source and the hasher's `ui_in`/`uio_in[0]` input and `uo_out`/`uio_out[1]` output.

## Interface
- `MAX_LEN`, default 55: largest accepted message length in bytes (single-block limit).
- `TIMEOUT`, default 511: maximum cycles allowed from the last strobe to the first digest-valid.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  command pulse; sampled only in IDLE.
- `msg_len`  in  6  message length; sampled with `start`.
- `src_valid`  in  1  upstream byte valid.
- `src_data`  in  8  upstream byte.
- `src_ready`  out  1  driver accepts a byte.
- `hs_byte`  out  8  byte to the hasher (drives its `ui_in`).
- `hs_strobe`  out  1  load strobe to the hasher (drives its `uio_in[0]`).
- `hs_digest`  in  8  digest byte from the hasher (`uo_out`).
- `hs_digest_valid`  in  1  digest byte valid (`uio_out[1]`).
- `digest`  out  256  last good digest; first byte received is `[255:248]`.
- `done`  out  1  one-cycle pulse; `digest` has just been updated.
- `busy`  out  1  high in every state except IDLE.
- `cmd_err`, `timeout_err`, `short_err`  out  1 each  one-cycle error pulses.

## Operation
States: IDLE, FILL, SEND, WAIT, CAPTURE, DONE.

- **IDLE**
  - `start` with `1 <= msg_len <= MAX_LEN`: latch the length, clear the pointers, go to FILL.
  - `start` with `msg_len` of 0 or greater than `MAX_LEN`: pulse `cmd_err`, stay in IDLE. The hasher cannot accept an empty message.
- **FILL**
  - `src_ready` = 1.
  - On `src_valid && src_ready`: write the byte to `buf[wr_ptr]` and increment `wr_ptr`.
  - When the final byte is accepted, `src_ready` drops in the next cycle and the state goes to SEND.
  - Upstream stalls are absorbed here and never reach the hasher.
- **SEND**
  - `hs_strobe` = 1 and `hs_byte` = `buf[rd_ptr]` for exactly `msg_len` consecutive cycles, with no gaps; the hasher treats a strobe gap as end of message.
  - Then `hs_strobe` = 0 and the state goes to WAIT with the timeout counter cleared.
- **WAIT**
  - The counter increments each cycle.
  - `hs_digest_valid` = 1: capture that byte as byte 0 in the same cycle and go to CAPTURE.
  - Counter reaches `TIMEOUT`: pulse `timeout_err` and go to IDLE.
- **CAPTURE**
  - Shift `hs_digest` into a 256-bit shadow register on each valid cycle, MSB-first.
  - After 32 bytes, go to DONE.
  - `hs_digest_valid` low before 32 bytes: pulse `short_err`, go to IDLE, `digest` unchanged.
- **DONE**
  - Copy the shadow register to `digest`, pulse `done`, go to IDLE.

Boundary rules:
- `hs_digest_valid` in IDLE, FILL or SEND is ignored.
- Valid cycles beyond the 32nd byte are ignored.
- `start` while `busy` is ignored.
- `digest` changes only in DONE.

## Timing
- Reset values: `src_ready`, `hs_strobe`, `done`, `busy` and all error outputs = 0; `hs_byte` = 0x00; `digest` = 0; state = IDLE. Reset asserted mid-operation forces these immediately and discards the buffer contents.
- All outputs are registered.
- `start` at cycle T: `busy` and `src_ready` are 1 at T+1.
- Last FILL accept at cycle F: first strobe at F+1; the strobe is high over F+1 .. F+`msg_len`.
- First digest-valid at cycle V: `done` at V+32. `digest` is valid from V+32 and holds until the next DONE or reset.
- `timeout_err` fires `TIMEOUT`+1 cycles after the last strobe cycle if no valid arrives.

## Structure
- Package `sha256_host_pkg` holds:
  - the state enum;
  - `DIGEST_BYTES` = 32;
  - `MAX_BLOCK_MSG` = 55;
  - the width constants for pointers and the timeout counter.
- Sub-module `sha256_msg_buffer`: a `MAX_LEN` × 8 register array with write and read ports and 6-bit pointers, cleared on reset.
- Top-level FSM, timeout counter and digest shadow register live in `sha256_host_driver`.

## Test plan
- **"abc" message**
  - Stimulus: `start`, `msg_len` = 3, bytes 0x61 0x62 0x63.
  - Required: `hs_strobe` high for exactly 3 contiguous cycles carrying 61/62/63.
  - With the hasher model returning the standard digest, `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and `done` pulses once.
- **Upstream stall**
  - Stimulus: `msg_len` = 10, `src_valid` toggling every cycle.
  - Required: strobe burst of exactly 10 contiguous cycles, bytes in order.
- **Illegal length**
  - Stimulus: `msg_len` = 0, then 56.
  - Required: `cmd_err` pulses for 1 cycle each time; `busy`, `src_ready` and `hs_strobe` stay 0.
- **Timeout**
  - Stimulus: hasher model never asserts valid.
  - Required: `timeout_err` exactly 512 cycles after the last strobe, then `busy` = 0 and `digest` unchanged.
- **Short digest**
  - Stimulus: valid drops after 20 bytes.
  - Required: `short_err` pulses, `done` is never asserted, `digest` keeps its previous value.
- **Reset mid-send**
  - Stimulus: `rst_n` low during SEND.
  - Required: `hs_strobe` and `busy` are 0 immediately; after release, a new "abc" transaction passes.
